// File: rtl/uart_pkg.sv
// Shared UART types, constants and small helpers.
package uart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PRESCALE_W = 5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // 2-of-3 majority vote
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Expected parity bit for a byte under the selected parity type
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic typ);
    logic p;
    p = ^d;
    if (typ == PAR_ODD) p = ~p;
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures three mid-bit samples of the serial line and votes on them.
// The voted bit is stable from edge_cnt = P/2+2 onward, so it is valid at P-1.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit_c
);

  logic [2:0]            samples_q;
  logic [2:0]            samples_d;
  logic [PRESCALE_W-1:0] half;

  assign half = prescale >> 1;

  // Pick up the line at P/2-1, P/2 and P/2+1
  always_comb begin
    samples_d = samples_q;
    if (edge_cnt == PRESCALE_W'(half - PRESCALE_W'(1))) samples_d[0] = rx_in;
    if (edge_cnt == half)                               samples_d[1] = rx_in;
    if (edge_cnt == PRESCALE_W'(half + PRESCALE_W'(1))) samples_d[2] = rx_in;
  end

  // Sample registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samples_q <= 3'b111;
    else        samples_q <= samples_d;
  end

  assign sampled_bit_c = majority3(samples_q);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional parity, one stop.
// Configuration is captured when a start bit is first seen and held for the frame.
module uart_rx
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  RX_IN,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  DATA_VALID
);

  rx_state_e             state_q,      state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q,   edge_cnt_d;
  logic [2:0]            bit_cnt_q,    bit_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q,   prescale_d;
  logic                  par_en_q,     par_en_d;
  logic                  par_typ_q,    par_typ_d;
  logic                  err_q,        err_d;
  logic [DATA_W-1:0]     shift_q,      shift_d;
  logic [DATA_W-1:0]     p_data_q,     p_data_d;
  logic                  data_valid_q, data_valid_d;

  logic sampled_bit_c;
  logic last_edge_c;

  uart_rx_sampler u_sampler (
    .clk           (CLK),
    .rst_n         (RST),
    .rx_in         (RX_IN),
    .edge_cnt      (edge_cnt_q),
    .prescale      (prescale_q),
    .sampled_bit_c (sampled_bit_c)
  );

  assign last_edge_c = (edge_cnt_q == PRESCALE_W'(prescale_q - PRESCALE_W'(1)));

  // Next-state, counters, shift register, parity check and output updates
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    err_d        = err_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = last_edge_c ? '0 : PRESCALE_W'(edge_cnt_q + PRESCALE_W'(1));
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (!RX_IN) begin
          // This cycle counts as edge 0 of the start bit
          state_d    = START;
          edge_cnt_d = PRESCALE_W'(1);
          bit_cnt_d  = '0;
          err_d      = 1'b0;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      START: begin
        if (last_edge_c) state_d = sampled_bit_c ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge_c) begin
          shift_d = {sampled_bit_c, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          end
        end
      end
      PARITY: begin
        if (last_edge_c) begin
          err_d   = (sampled_bit_c != parity_bit(shift_q, par_typ_q));
          state_d = STOP;
        end
      end
      STOP: begin
        if (last_edge_c) begin
          if (sampled_bit_c && !err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      prescale_q   <= PRESCALE_W'(16);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      err_q        <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      err_q        <= err_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected bytes and arrival cycles.
module tb_uart_rx;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       RX_IN;
  logic [7:0] P_DATA;
  logic       DATA_VALID;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          dv_count = 0;
  logic        dv_prev = 1'b0;
  exp_t        sb[$];

  uart_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .RX_IN      (RX_IN),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID)
  );

  always #20 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1 && DATA_VALID === 1'b1) begin
      dv_count++;
      check("dv_one_cycle", 32'(dv_prev), 32'd0);
      check("dv_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("p_data", 32'(P_DATA), 32'(e.data));
        check("dv_cycle", cyc, e.cyc);
      end
    end
    dv_prev = DATA_VALID;
  end

  // Send one frame; must be called at a negedge and returns at a negedge
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic bad_par, input logic stop_v,
                            input logic expect_ok);
    exp_t e;
    PRESCALE = 5'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    RX_IN    = 1'b0;
    e.data   = d;
    e.cyc    = cyc + 1 + (pen ? 11 : 10) * p - 1;
    if (expect_ok) sb.push_back(e);
    @(negedge CLK);
    // Config changes mid-frame must be ignored
    PRESCALE = 5'd12;
    PAR_EN   = ~pen;
    PAR_TYP  = ~ptyp;
    repeat (p - 1) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge CLK);
    end
    if (pen) begin
      RX_IN = (^d) ^ ptyp ^ bad_par;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stop_v;
    repeat (p) @(negedge CLK);
    RX_IN    = 1'b1;
    PRESCALE = 5'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PRESCALE = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_p_data", 32'(P_DATA), 32'h00);
    check("rst_dv", 32'(DATA_VALID), 32'd0);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // P=8, no parity
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    check("a5_count", 32'(dv_count), 32'd1);
    check("a5_hold", 32'(P_DATA), 32'hA5);

    // P=16, even parity
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    check("3c_count", 32'(dv_count), 32'd2);
    check("3c_hold", 32'(P_DATA), 32'h3C);

    // P=8, odd parity, correct parity bit
    send_frame(8'h96, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    check("96_count", 32'(dv_count), 32'd3);

    // P=8, odd parity, wrong parity bit
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    check("parerr_count", 32'(dv_count), 32'd3);
    check("parerr_hold", 32'(P_DATA), 32'h96);

    // Start glitch, then a good frame
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    check("glitch_count", 32'(dv_count), 32'd3);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    check("81_count", 32'(dv_count), 32'd4);
    check("81_hold", 32'(P_DATA), 32'h81);

    // Framing error, then back-to-back frames
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    check("frm_count", 32'(dv_count), 32'd4);
    check("frm_hold", 32'(P_DATA), 32'h81);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    check("b2b_count", 32'(dv_count), 32'd6);
    check("b2b_hold", 32'(P_DATA), 32'h34);

    // Reset in the middle of a frame
    PRESCALE = 5'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (12) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midrst_p_data", 32'(P_DATA), 32'h00);
    check("midrst_dv", 32'(DATA_VALID), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (100) @(negedge CLK);
    check("midrst_count", 32'(dv_count), 32'd6);
    check("midrst_hold", 32'(P_DATA), 32'h00);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    check("5a_count", 32'(dv_count), 32'd7);
    check("5a_hold", 32'(P_DATA), 32'h5A);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
